// File: rtl/mips_sim_pkg.sv
// Shared types and defaults for the MIPS simulation self-check logic.
package mips_sim_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefSelW  = 5;

  // Result checker sequencing states.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitPc  = 3'd1,
    StDelay   = 3'd2,
    StCompare = 3'd3,
    StDone    = 3'd4
  } chk_state_e;

  // One checkpoint: when the core reaches pc, register sel must hold exp.
  typedef struct packed {
    logic [DefDataW-1:0] pc;
    logic [DefSelW-1:0]  sel;
    logic [DefDataW-1:0] exp;
  } checkpoint_t;

endpackage

// File: rtl/sim_watchdog.sv
// Per-checkpoint wait timer: counts enabled cycles and flags the last allowed one.
module sim_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q;

  // Saturating cycle counter; clear has priority over counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // High during the TIMEOUT_CYC-th enabled cycle, so the run ends on that edge.
  assign expired = en && (cnt_q >= CntLast);

endmodule

// File: rtl/mips_result_checker.sv
// Self-check monitor: walks a checkpoint table, waits for each PC, then compares
// the selected register against the expected value.
module mips_result_checker
  import mips_sim_pkg::*;
#(
  parameter int unsigned NUM_CHECKS  = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned SEL_W       = DefSelW,
  parameter int unsigned SAMPLE_DLY  = 2,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [IDX_W:0]    num_checks,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_pc,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [DATA_W-1:0] cfg_exp,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] disp_dat,
  output logic [SEL_W-1:0]  disp_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [DATA_W-1:0] fail_got,
  output logic [IDX_W:0]    n_passed
);

  localparam logic [IDX_W:0] NumMax  = (IDX_W + 1)'(NUM_CHECKS);
  // DELAY is held for SAMPLE_DLY cycles: load SAMPLE_DLY-1 and leave on zero.
  localparam logic [3:0]     DlyInit = (SAMPLE_DLY == 0) ? 4'd0 : 4'(SAMPLE_DLY - 1);

  logic [DATA_W-1:0] tbl_pc_q  [NUM_CHECKS];
  logic [SEL_W-1:0]  tbl_sel_q [NUM_CHECKS];
  logic [DATA_W-1:0] tbl_exp_q [NUM_CHECKS];

  chk_state_e        state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W:0]    run_n_q;
  logic [3:0]        dly_q;
  logic              done_q, pass_q, timeout_q;
  logic [IDX_W-1:0]  fail_idx_q;
  logic [DATA_W-1:0] fail_got_q;
  logic [IDX_W:0]    n_passed_q;

  logic              wd_expired;
  logic              cfg_ok;
  logic              is_last;
  logic [IDX_W:0]    num_clamped;

  assign busy        = (state_q == StWaitPc) || (state_q == StDelay) || (state_q == StCompare);
  assign cfg_ok      = cfg_we && !busy && ({1'b0, cfg_idx} < NumMax);
  assign is_last     = (({1'b0, idx_q} + (IDX_W + 1)'(1)) == run_n_q);
  assign num_clamped = (num_checks > NumMax) ? NumMax : num_checks;

  sim_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (state_q != StWaitPc),
    .en     (state_q == StWaitPc),
    .expired(wd_expired)
  );

  // Checkpoint table; writable only while no run is in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_pc_q[i]  <= '0;
        tbl_sel_q[i] <= '0;
        tbl_exp_q[i] <= '0;
      end
    end else if (cfg_ok) begin
      tbl_pc_q[cfg_idx]  <= cfg_pc;
      tbl_sel_q[cfg_idx] <= cfg_sel;
      tbl_exp_q[cfg_idx] <= cfg_exp;
    end
  end

  // Run sequencer and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      run_n_q    <= '0;
      dly_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fail_idx_q <= '0;
      fail_got_q <= '0;
      n_passed_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            fail_idx_q <= '0;
            fail_got_q <= '0;
            n_passed_q <= '0;
            idx_q      <= '0;
            run_n_q    <= num_clamped;
            if (num_clamped == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= StWaitPc;
            end
          end
        end
        StWaitPc: begin
          // A match on the expiry cycle still counts as a match.
          if (pc == tbl_pc_q[idx_q]) begin
            dly_q   <= DlyInit;
            state_q <= (SAMPLE_DLY == 0) ? StCompare : StDelay;
          end else if (wd_expired) begin
            state_q    <= StDone;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
            pass_q     <= 1'b0;
            fail_idx_q <= idx_q;
          end
        end
        StDelay: begin
          if (dly_q == 4'd0) begin
            state_q <= StCompare;
          end else begin
            dly_q <= dly_q - 4'd1;
          end
        end
        StCompare: begin
          if (disp_dat == tbl_exp_q[idx_q]) begin
            n_passed_q <= n_passed_q + (IDX_W + 1)'(1);
            if (is_last) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= StWaitPc;
            end
          end else begin
            state_q    <= StDone;
            done_q     <= 1'b1;
            pass_q     <= 1'b0;
            fail_idx_q <= idx_q;
            fail_got_q <= disp_dat;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign disp_sel = busy ? tbl_sel_q[idx_q] : '0;
  assign done     = done_q;
  assign pass     = pass_q;
  assign timeout  = timeout_q;
  assign fail_idx = fail_idx_q;
  assign fail_got = fail_got_q;
  assign n_passed = n_passed_q;

endmodule

// File: tb/tb_mips_result_checker.sv
// Directed bench for mips_result_checker: two instances share stimulus, one with
// SAMPLE_DLY=2 and one with SAMPLE_DLY=0, both with a 20-cycle watchdog.
module tb_mips_result_checker;
  import mips_sim_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  num_checks;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_pc;
  logic [4:0]  cfg_sel;
  logic [31:0] cfg_exp;
  logic [31:0] pc;
  logic [31:0] disp_dat_a, disp_dat_b;
  logic [4:0]  disp_sel_a, disp_sel_b;
  logic        busy_a, done_a, pass_a, timeout_a;
  logic        busy_b, done_b, pass_b, timeout_b;
  logic [1:0]  fail_idx_a, fail_idx_b;
  logic [31:0] fail_got_a, fail_got_b;
  logic [2:0]  n_passed_a, n_passed_b;

  // Register-file model for the display port, or a forced value.
  logic [31:0] rf [32];
  logic        use_rf;
  logic [31:0] disp_force;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    disp_dat_a = use_rf ? rf[disp_sel_a] : disp_force;
    disp_dat_b = use_rf ? rf[disp_sel_b] : disp_force;
  end

  mips_result_checker #(
    .NUM_CHECKS(4), .IDX_W(2), .DATA_W(32), .SEL_W(5), .SAMPLE_DLY(2), .TIMEOUT_CYC(20)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .num_checks(num_checks),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc), .cfg_sel(cfg_sel), .cfg_exp(cfg_exp),
    .pc(pc), .disp_dat(disp_dat_a), .disp_sel(disp_sel_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .timeout(timeout_a), .fail_idx(fail_idx_a), .fail_got(fail_got_a),
    .n_passed(n_passed_a)
  );

  mips_result_checker #(
    .NUM_CHECKS(4), .IDX_W(2), .DATA_W(32), .SEL_W(5), .SAMPLE_DLY(0), .TIMEOUT_CYC(20)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .num_checks(num_checks),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc), .cfg_sel(cfg_sel), .cfg_exp(cfg_exp),
    .pc(pc), .disp_dat(disp_dat_b), .disp_sel(disp_sel_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .timeout(timeout_b), .fail_idx(fail_idx_b), .fail_got(fail_got_b),
    .n_passed(n_passed_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All drive tasks start and end just after a falling edge.
  task automatic write_entry(input logic [1:0] idx, input checkpoint_t cp);
    cfg_we  = 1'b1;
    cfg_idx = idx;
    cfg_pc  = cp.pc;
    cfg_sel = cp.sel;
    cfg_exp = cp.exp;
    @(negedge clk);
    cfg_we  = 1'b0;
  endtask

  task automatic start_run(input logic [2:0] n);
    num_checks = n;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic ramp_pc(input logic [31:0] target, input int hold);
    for (int i = 0; i < 64 && pc != target; i++) begin
      pc = pc + 32'd4;
      @(negedge clk);
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60 && !(done_a && done_b); i++) @(negedge clk);
    check_eq(tag, {31'd0, done_a & done_b}, 32'd1);
  endtask

  task automatic load_four();
    write_entry(2'd0, checkpoint_t'{pc: 32'h10, sel: 5'd1, exp: 32'hA});
    write_entry(2'd1, checkpoint_t'{pc: 32'h20, sel: 5'd2, exp: 32'hB});
    write_entry(2'd2, checkpoint_t'{pc: 32'h30, sel: 5'd3, exp: 32'hC});
    write_entry(2'd3, checkpoint_t'{pc: 32'h40, sel: 5'd4, exp: 32'hD});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int cyc;
    logic seen;
    reset_n = 1'b0; start = 1'b0; num_checks = '0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_pc = '0; cfg_sel = '0; cfg_exp = '0; pc = '0; use_rf = 1'b0; disp_force = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'hA; rf[2] = 32'hB; rf[3] = 32'hC; rf[4] = 32'hD;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
    check_eq("rst_done", {31'd0, done_a}, 32'd0);
    check_eq("rst_pass", {31'd0, pass_a}, 32'd0);
    check_eq("rst_n_passed", {29'd0, n_passed_a}, 32'd0);
    check_eq("rst_disp_sel", {27'd0, disp_sel_a}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: single entry passes.
    disp_force = 32'h18;
    write_entry(2'd0, checkpoint_t'{pc: 32'h30, sel: 5'd16, exp: 32'h18});
    start_run(3'd1);
    check_eq("t1_busy", {31'd0, busy_a}, 32'd1);
    check_eq("t1_disp_sel", {27'd0, disp_sel_a}, 32'd16);
    ramp_pc(32'h30, 2);
    wait_done("t1_done");
    check_eq("t1_pass", {31'd0, pass_a}, 32'd1);
    check_eq("t1_n_passed", {29'd0, n_passed_a}, 32'd1);
    check_eq("t1_timeout", {31'd0, timeout_a}, 32'd0);
    check_eq("t1_idle_sel", {27'd0, disp_sel_a}, 32'd0);

    // 2: same entry, wrong data.
    disp_force = 32'h17;
    pc = 32'h0;
    start_run(3'd1);
    check_eq("t2_done_cleared", {31'd0, done_a}, 32'd0);
    ramp_pc(32'h30, 2);
    wait_done("t2_done");
    check_eq("t2_pass", {31'd0, pass_a}, 32'd0);
    check_eq("t2_fail_idx", {30'd0, fail_idx_a}, 32'd0);
    check_eq("t2_fail_got", fail_got_a, 32'h17);

    // 6b: cfg_we and start while busy are ignored.
    disp_force = 32'h18;
    pc = 32'h0;
    start_run(3'd1);
    write_entry(2'd0, checkpoint_t'{pc: 32'h40, sel: 5'd3, exp: 32'h99});
    ramp_pc(32'h30, 0);
    pc = 32'h34;
    start_run(3'd1);
    wait_done("t6b_done");
    check_eq("t6b_pass_a", {31'd0, pass_a}, 32'd1);
    check_eq("t6b_pass_b", {31'd0, pass_b}, 32'd1);
    pc = 32'h0;
    start_run(3'd1);
    ramp_pc(32'h30, 2);
    wait_done("t6b_rerun_done");
    check_eq("t6b_rerun_pass", {31'd0, pass_a}, 32'd1);
    check_eq("t6b_rerun_sel", {27'd0, disp_sel_a}, 32'd0);

    // 6c: match on the expiry cycle wins; one cycle later times out.
    pc = 32'h100;
    start_run(3'd1);
    repeat (19) @(negedge clk);
    pc = 32'h30;
    @(negedge clk);
    pc = 32'h100;
    wait_done("t6c_done");
    check_eq("t6c_pass", {31'd0, pass_a}, 32'd1);
    check_eq("t6c_timeout", {31'd0, timeout_a}, 32'd0);
    start_run(3'd1);
    repeat (20) @(negedge clk);
    pc = 32'h30;
    @(negedge clk);
    pc = 32'h100;
    wait_done("t6c_late_done");
    check_eq("t6c_late_timeout", {31'd0, timeout_a}, 32'd1);
    check_eq("t6c_late_pass", {31'd0, pass_a}, 32'd0);

    // 3: entry 2 never reached -> timeout 20 cycles after entry 1 compare.
    load_four();
    use_rf = 1'b1;
    pc = 32'h0;
    start_run(3'd4);
    ramp_pc(32'h10, 4);
    ramp_pc(32'h20, 0);
    pc = 32'h24;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (n_passed_a == 3'd2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("t3_reach_e2", {31'd0, seen}, 32'd1);
    cyc = 0;
    while (!timeout_a && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t3_timeout_cycles", cyc, 32'd20);
    wait_done("t3_done");
    check_eq("t3_timeout", {31'd0, timeout_a}, 32'd1);
    check_eq("t3_pass", {31'd0, pass_a}, 32'd0);
    check_eq("t3_fail_idx", {30'd0, fail_idx_a}, 32'd2);
    check_eq("t3_n_passed", {29'd0, n_passed_a}, 32'd2);
    check_eq("t3_fail_got", fail_got_a, 32'd0);
    check_eq("t3_b_n_passed", {29'd0, n_passed_b}, 32'd2);

    // 4: data valid only from 2 cycles after match.
    use_rf = 1'b0;
    disp_force = 32'h11;
    write_entry(2'd0, checkpoint_t'{pc: 32'h60, sel: 5'd5, exp: 32'h55});
    pc = 32'h5C;
    start_run(3'd1);
    @(negedge clk);
    pc = 32'h60;
    @(negedge clk);
    pc = 32'h64;
    @(negedge clk);
    disp_force = 32'h55;
    wait_done("t4_done");
    check_eq("t4_dly2_pass", {31'd0, pass_a}, 32'd1);
    check_eq("t4_dly0_pass", {31'd0, pass_b}, 32'd0);
    check_eq("t4_dly0_fail_got", fail_got_b, 32'h11);
    check_eq("t4_dly0_fail_idx", {30'd0, fail_idx_b}, 32'd0);

    // 5: zero entries, then clamp 7 -> 4.
    start_run(3'd0);
    check_eq("t5_zero_done", {31'd0, done_a}, 32'd1);
    check_eq("t5_zero_pass", {31'd0, pass_a}, 32'd1);
    check_eq("t5_zero_busy", {31'd0, busy_a}, 32'd0);
    load_four();
    use_rf = 1'b1;
    pc = 32'h0;
    start_run(3'd7);
    ramp_pc(32'h10, 4);
    ramp_pc(32'h20, 4);
    ramp_pc(32'h30, 4);
    ramp_pc(32'h40, 4);
    wait_done("t5_clamp_done");
    check_eq("t5_clamp_pass", {31'd0, pass_a}, 32'd1);
    check_eq("t5_clamp_n_passed", {29'd0, n_passed_a}, 32'd4);
    check_eq("t5_clamp_pass_b", {31'd0, pass_b}, 32'd1);

    // 6a: asynchronous reset during DELAY.
    pc = 32'h0;
    start_run(3'd2);
    ramp_pc(32'h10, 4);
    ramp_pc(32'h20, 0);
    check_eq("t6a_pre_busy", {31'd0, busy_a}, 32'd1);
    check_eq("t6a_pre_n_passed", {29'd0, n_passed_a}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6a_busy", {31'd0, busy_a}, 32'd0);
    check_eq("t6a_n_passed", {29'd0, n_passed_a}, 32'd0);
    check_eq("t6a_disp_sel", {27'd0, disp_sel_a}, 32'd0);
    check_eq("t6a_done", {31'd0, done_a}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // Table was cleared: entry 0 is now {pc 0, sel 0, exp 0}.
    use_rf = 1'b0;
    disp_force = 32'h0;
    pc = 32'h100;
    start_run(3'd1);
    pc = 32'h0;
    @(negedge clk);
    pc = 32'h100;
    wait_done("t6a_post_done");
    check_eq("t6a_post_pass", {31'd0, pass_a}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
